line_buffer_ctrl: RTL and testbench
===================================

Name: line_buffer_ctrl

Overview:
- Sequences four external 512-deep 8-bit line buffers for the 3x3 spatial filter front end.
- Writes the incoming pixel stream round-robin into one line buffer at a time.
- Once three full lines are stored, reads three buffers in lockstep and presents a 72-bit 3x3 window to the filter core, with consumer backpressure.
- Pulses an interrupt after each output line so the DMA/host can send the next line.

Parameters:
- LINE_WIDTH, 512: pixels per line. Must equal the line buffer depth; power of two.
- CNT_W, 12: fill-counter width. Holds 0..4*LINE_WIDTH.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_pixel_data  in  8  input pixel.
- i_pixel_valid  in  1  input pixel qualifier.
- o_lb_wr_data  out  8  write data broadcast to all four line buffers.
- o_lb_wr_valid  out  4  per-buffer write valid, one-hot or zero.
- o_lb_rd  out  4  per-buffer read-advance strobes.
- i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data  in  24 each  three consecutive pixels from each buffer's read pointer.
- o_pixel_data  out  72  window, {top row, middle row, bottom row}.
- o_pixel_valid  out  1  window valid.
- i_win_ready  in  1  consumer accepts window this cycle.
- o_intr  out  1  one-cycle pulse per completed output line.
- o_overflow  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): all state cleared; every output 0. wr_sel=0, wr_cnt=0, rd_sel=0, rd_cnt=0, fill=0, state IDLE.
- Write path, combinational:
  - o_lb_wr_data = i_pixel_data.
  - o_lb_wr_valid = onehot(wr_sel) when a write is accepted, else 0.
- Accepted write: wr_cnt increments. When wr_cnt==LINE_WIDTH-1 it wraps to 0 and wr_sel increments mod 4.
- fill counter:
  - +1 on accepted write, -1 on read handshake, unchanged when both occur in the same cycle.
  - Never exceeds 4*LINE_WIDTH.
- FSM, states IDLE and RD_LINE:
  - IDLE -> RD_LINE when fill >= 3*LINE_WIDTH, evaluated on the registered fill value. Read begins the next cycle.
  - RD_LINE: o_pixel_valid=1.
  - Handshake when o_pixel_valid & i_win_ready.
  - o_lb_rd = (onehot(rd_sel)|onehot(rd_sel+1)|onehot(rd_sel+2)) gated by i_win_ready, indices mod 4.
  - Each handshake increments rd_cnt.
  - Handshake with rd_cnt==LINE_WIDTH-1: rd_cnt->0, rd_sel increments mod 4, state->IDLE, o_intr=1 for exactly the following cycle.
  - IDLE always spends at least one cycle before re-entering RD_LINE.
- Window mux, combinational, zero latency from buffer outputs: o_pixel_data = {i_lbN(rd_sel), i_lbN(rd_sel+1), i_lbN(rd_sel+2)}.
  - Top row is the oldest line.
  - o_pixel_data is 0 when o_pixel_valid=0.
- Valid/data stability: valid and data stay stable while i_win_ready=0. A deasserted ready stalls rd_cnt and o_lb_rd.
- Edge columns: all LINE_WIDTH positions are issued per line. The last two windows contain wrapped columns; the consumer discards them.
- Writes into the fourth buffer proceed concurrently with reads.
- Reset mid-line: counters and FSM restart from zero. Line buffers must be reset in the same event.

Optional Feature:
- Macro LB_OVERFLOW_PROTECT_EN.
- Defined:
  - A write arriving when fill==4*LINE_WIDTH with no read handshake that cycle is dropped: o_lb_wr_valid=0, wr_cnt/wr_sel/fill unchanged.
  - o_overflow sets the next cycle and stays 1 until reset.
- Undefined:
  - Writes are always forwarded and pointers always advance, overwriting the oldest line.
  - fill saturates at 4*LINE_WIDTH.
  - o_overflow is tied 0.

Test Plan:
- Reset: assert i_rst_n=0 mid-stream, with no clock edge -> all outputs 0 immediately. After release, first write gives o_lb_wr_valid=4'b0001.
- Fill: send 1535 pixels -> o_pixel_valid stays 0. Send the 1536th -> o_pixel_valid=1 and o_lb_rd=4'b0111 one cycle later.
- Window and interrupt: line k pixels all = k+1, i_win_ready=1 -> first window 72'h010101_020202_030303. Exactly 512 valid cycles, then o_intr=1 for one cycle.
- Rotation: send a fourth line, drain -> second read has o_lb_rd=4'b1110 and window 72'h020202_030303_040404. Fifth line goes to buffer 0 (o_lb_wr_valid=4'b0001).
- Backpressure: i_win_ready=0 for 10 cycles mid-line -> o_lb_rd=0, window value held, rd_cnt frozen. Still exactly 512 handshakes per line.
- Overflow (macro defined): hold i_win_ready=0, stream 2049 pixels -> pixel 2049 not written, o_overflow=1 sticky. Macro undefined -> o_lb_wr_valid=4'b0001 on pixel 2049, o_overflow=0.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences four external line buffers into a 3x3 window stream.
//
// Writes the incoming pixel stream round-robin into one of four line buffers,
// and once three full lines are stored reads three of them in lockstep to
// present a 72-bit {top, middle, bottom} window with consumer backpressure.
// o_intr pulses for one cycle after each output line has been issued.
//
// Optional feature: define LB_OVERFLOW_PROTECT_EN to drop writes that would
// overrun a full set of buffers and raise a sticky o_overflow. Without it,
// writes always advance (overwriting the oldest line) and o_overflow is 0.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_pixel_data/valid    incoming pixel stream
//   o_lb_wr_data/valid    write data broadcast and one-hot per-buffer write enable
//   o_lb_rd               per-buffer read-advance strobes
//   i_lb0..3_data         three consecutive pixels at each buffer's read pointer
//   o_pixel_data/valid    3x3 window and its qualifier
//   i_win_ready           consumer accepts the window this cycle
//   o_intr                one-cycle pulse per completed output line
//   o_overflow            sticky overflow flag
module line_buffer_ctrl #(
    parameter int LINE_WIDTH = 512,
    parameter int CNT_W      = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_valid,
    output logic [7:0]  o_lb_wr_data,
    output logic [3:0]  o_lb_wr_valid,
    output logic [3:0]  o_lb_rd,
    input  logic [23:0] i_lb0_data,
    input  logic [23:0] i_lb1_data,
    input  logic [23:0] i_lb2_data,
    input  logic [23:0] i_lb3_data,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_valid,
    input  logic        i_win_ready,
    output logic        o_intr,
    output logic        o_overflow
);
    localparam int PW = $clog2(LINE_WIDTH);
    localparam logic [PW-1:0]    LAST     = PW'(LINE_WIDTH - 1);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(4 * LINE_WIDTH);
    localparam logic [CNT_W-1:0] FILL_RD  = CNT_W'(3 * LINE_WIDTH);

    typedef enum logic {IDLE, RD_LINE} state_t;

    state_t           r_state;
    logic [1:0]       r_wr_sel;
    logic [1:0]       r_rd_sel;
    logic [PW-1:0]    r_wr_cnt;
    logic [PW-1:0]    r_rd_cnt;
    logic [CNT_W-1:0] r_fill;
    logic             r_intr;

    logic             w_hs;
    logic             w_wr;
    logic             w_full;
    logic             w_rd_last;
    logic [1:0]       w_sel1;
    logic [1:0]       w_sel2;
    logic [23:0]      w_lb [4];

    assign w_lb[0] = i_lb0_data;
    assign w_lb[1] = i_lb1_data;
    assign w_lb[2] = i_lb2_data;
    assign w_lb[3] = i_lb3_data;

    assign w_sel1        = r_rd_sel + 2'd1;
    assign w_sel2        = r_rd_sel + 2'd2;
    assign o_pixel_valid = (r_state == RD_LINE);
    assign w_hs          = o_pixel_valid & i_win_ready;
    assign w_full        = (r_fill == FILL_MAX);
    assign w_rd_last     = (r_rd_cnt == LAST);

    // The reset term keeps every output at 0 the instant reset asserts.
`ifdef LB_OVERFLOW_PROTECT_EN
    assign w_wr = i_rst_n & i_pixel_valid & ~(w_full & ~w_hs);
`else
    assign w_wr = i_rst_n & i_pixel_valid;
`endif

    assign o_lb_wr_data  = i_rst_n ? i_pixel_data : 8'd0;
    assign o_lb_wr_valid = w_wr ? (4'b0001 << r_wr_sel) : 4'b0000;
    assign o_lb_rd       = w_hs ? ((4'b0001 << r_rd_sel) | (4'b0001 << w_sel1) | (4'b0001 << w_sel2)) : 4'b0000;
    assign o_pixel_data  = o_pixel_valid ? {w_lb[r_rd_sel], w_lb[w_sel1], w_lb[w_sel2]} : 72'd0;
    assign o_intr        = r_intr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_wr_sel <= 2'd0;
            r_rd_sel <= 2'd0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_fill   <= '0;
            r_intr   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + PW'(1);
                if (r_wr_cnt == LAST) r_wr_sel <= r_wr_sel + 2'd1;
            end
            // Saturating at FILL_MAX lets overwrite mode keep streaming.
            if (w_wr && !w_hs && !w_full) r_fill <= r_fill + CNT_W'(1);
            else if (w_hs && !w_wr) r_fill <= r_fill - CNT_W'(1);
            r_intr <= w_hs & w_rd_last;
            if (w_hs) begin
                r_rd_cnt <= r_rd_cnt + PW'(1);
                if (w_rd_last) begin
                    r_rd_sel <= r_rd_sel + 2'd1;
                    r_state  <= IDLE;
                end
            end else if (r_state == IDLE && r_fill >= FILL_RD) begin
                r_state <= RD_LINE;
            end
        end
    end

`ifdef LB_OVERFLOW_PROTECT_EN
    logic r_overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_overflow <= 1'b0;
        else if (i_pixel_valid && !w_wr) r_overflow <= 1'b1;
    end

    assign o_overflow = r_overflow;
`else
    assign o_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_line_buffer_ctrl.sv
// tb_line_buffer_ctrl: self-checking bench for line_buffer_ctrl with a pixel-count model.
module tb_line_buffer_ctrl;
    localparam int LW = 512;
`ifdef LB_OVERFLOW_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_valid;
    logic [7:0]  o_lb_wr_data;
    logic [3:0]  o_lb_wr_valid;
    logic [3:0]  o_lb_rd;
    logic [23:0] i_lb0_data;
    logic [23:0] i_lb1_data;
    logic [23:0] i_lb2_data;
    logic [23:0] i_lb3_data;
    logic [71:0] o_pixel_data;
    logic        o_pixel_valid;
    logic        i_win_ready;
    logic        o_intr;
    logic        o_overflow;

    always #5 i_clk = ~i_clk;

    line_buffer_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_pixel_data(i_pixel_data), .i_pixel_valid(i_pixel_valid),
        .o_lb_wr_data(o_lb_wr_data), .o_lb_wr_valid(o_lb_wr_valid), .o_lb_rd(o_lb_rd),
        .i_lb0_data(i_lb0_data), .i_lb1_data(i_lb1_data),
        .i_lb2_data(i_lb2_data), .i_lb3_data(i_lb3_data),
        .o_pixel_data(o_pixel_data), .o_pixel_valid(o_pixel_valid),
        .i_win_ready(i_win_ready), .o_intr(o_intr), .o_overflow(o_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // External line buffers driven purely by the DUT's strobes.
    logic [7:0]  mem [4][LW];
    int          wp [4];
    int          rp [4];
    logic [23:0] lbq [4];

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int b = 0; b < 4; b++) begin
                wp[b] <= 0;
                rp[b] <= 0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (o_lb_wr_valid[b]) begin
                    mem[b][wp[b]] <= o_lb_wr_data;
                    wp[b] <= (wp[b] + 1) % LW;
                end
                if (o_lb_rd[b]) rp[b] <= (rp[b] + 1) % LW;
            end
        end
    end

    always_comb
        for (int b = 0; b < 4; b++)
            lbq[b] = {mem[b][rp[b]], mem[b][(rp[b] + 1) % LW], mem[b][(rp[b] + 2) % LW]};

    assign i_lb0_data = lbq[0];
    assign i_lb1_data = lbq[1];
    assign i_lb2_data = lbq[2];
    assign i_lb3_data = lbq[3];

    // Model: pixel n lands in buffer (n/LW)%4 at column n%LW; line L is read from buffer L%4.
    logic [7:0] mbuf [4][LW];
    int m_wr, m_fill, m_rdcnt, m_rdline;
    bit m_reading, m_intr, m_ovf;

    function automatic bit f_hs();
        return m_reading && i_win_ready;
    endfunction

    function automatic bit f_acc();
        return i_pixel_valid && !(PROT && m_fill == 4 * LW && !f_hs());
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << (i % 4);
    endfunction

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_wr <= 0; m_fill <= 0; m_rdcnt <= 0; m_rdline <= 0;
            m_reading <= 0; m_intr <= 0; m_ovf <= 0;
        end else begin
            if (f_acc()) begin
                mbuf[(m_wr / LW) % 4][m_wr % LW] <= i_pixel_data;
                m_wr <= m_wr + 1;
            end
            if (f_acc() && !f_hs()) m_fill <= (m_fill < 4 * LW) ? m_fill + 1 : m_fill;
            else if (f_hs() && !f_acc()) m_fill <= m_fill - 1;
            m_intr <= f_hs() && m_rdcnt == LW - 1;
            m_ovf <= m_ovf || (i_pixel_valid && !f_acc());
            if (f_hs()) begin
                if (m_rdcnt == LW - 1) begin
                    m_rdcnt <= 0;
                    m_rdline <= m_rdline + 1;
                    m_reading <= 0;
                end else begin
                    m_rdcnt <= m_rdcnt + 1;
                end
            end else if (!m_reading && m_fill >= 3 * LW) begin
                m_reading <= 1;
            end
        end
    end

    always @(negedge i_clk) begin
        logic [71:0] ew;
        if (i_rst_n) begin
            ew = '0;
            if (m_reading)
                for (int k = 0; k < 3; k++)
                    for (int j = 0; j < 3; j++)
                        ew[71 - 24 * k - 8 * j -: 8] = mbuf[(m_rdline + k) % 4][(m_rdcnt + j) % LW];
            chk("wr_data", o_lb_wr_data, i_pixel_data);
            chk("wr_valid", o_lb_wr_valid, f_acc() ? oh(m_wr / LW) : 4'b0);
            chk("lb_rd", o_lb_rd, f_hs() ? (oh(m_rdline) | oh(m_rdline + 1) | oh(m_rdline + 2)) : 4'b0);
            chk("window", o_pixel_data, ew);
            chk("pix_valid", o_pixel_valid, m_reading);
            chk("intr", o_intr, m_intr);
            chk("overflow", o_overflow, m_ovf);
        end
    end

    task automatic send(input logic [7:0] v);
        i_pixel_data = v;
        i_pixel_valid = 1'b1;
        @(posedge i_clk); #1;
        i_pixel_valid = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic read_line(input bit bp);
        int n = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [71:0] w;
        while (n < LW && cyc < 4 * LW) begin
            if (bp && n == 200 && !stalled) begin
                stalled = 1;
                i_win_ready = 1'b0;
                #1;
                w = o_pixel_data;
                chk("stall_rd", o_lb_rd, 4'b0);
                repeat (10) begin
                    @(posedge i_clk); #1;
                    chk("stall_win", o_pixel_data, w);
                    chk("stall_rd", o_lb_rd, 4'b0);
                    chk("stall_valid", o_pixel_valid, 1);
                end
                i_win_ready = 1'b1;
                #1;
            end
            if (o_pixel_valid && i_win_ready) n++;
            @(posedge i_clk); #1;
            cyc++;
        end
        chk("hs_count", n, LW);
        chk("intr_pulse", o_intr, 1);
        chk("valid_end", o_pixel_valid, 0);
        @(posedge i_clk); #1;
        chk("intr_clear", o_intr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_pixel_valid = 1'b0;
        i_pixel_data = 8'd0;
        i_win_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_pixel_valid, 0);
        chk("rst_wrv", o_lb_wr_valid, 0);
        i_rst_n = 1'b1;
        send_n(8'h55, 100);
        i_pixel_data = 8'hAA;
        i_pixel_valid = 1'b1;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_wr_data", o_lb_wr_data, 0);
        chk("arst_wr_valid", o_lb_wr_valid, 0);
        chk("arst_rd", o_lb_rd, 0);
        chk("arst_window", o_pixel_data, 0);
        chk("arst_valid", o_pixel_valid, 0);
        chk("arst_intr", o_intr, 0);
        chk("arst_ovf", o_overflow, 0);
        i_pixel_valid = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_pixel_data = 8'd1;
        i_pixel_valid = 1'b1;
        #1;
        chk("first_wr", o_lb_wr_valid, 4'b0001);
        @(posedge i_clk); #1;
        i_pixel_valid = 1'b0;
        send_n(8'd1, LW - 1);
        send_n(8'd2, LW);
        send_n(8'd3, LW - 1);
        chk("fill_1535", o_pixel_valid, 0);
        send(8'd3);
        @(posedge i_clk); #1;
        chk("fill_valid", o_pixel_valid, 1);
        chk("fill_rd", o_lb_rd, 4'b0111);
        chk("win_first", o_pixel_data, 72'h010101_020202_030303);
        read_line(1'b1);
        send_n(8'd4, LW);
        @(posedge i_clk); #1;
        chk("rot_rd", o_lb_rd, 4'b1110);
        chk("rot_win", o_pixel_data, 72'h020202_030303_040404);
        fork
            begin
                i_pixel_data = 8'd5;
                i_pixel_valid = 1'b1;
                #1;
                chk("line5_wr", o_lb_wr_valid, 4'b0001);
                @(posedge i_clk); #1;
                i_pixel_valid = 1'b0;
                send_n(8'd5, LW - 1);
            end
            read_line(1'b0);
        join
        read_line(1'b0);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_win_ready = 1'b0;
        for (int i = 0; i < 4 * LW; i++) send(8'(i));
        i_pixel_data = 8'hEE;
        i_pixel_valid = 1'b1;
        #1;
        chk("ovf_wr", o_lb_wr_valid, PROT ? 4'b0000 : 4'b0001);
        @(posedge i_clk); #1;
        i_pixel_valid = 1'b0;
        chk("ovf_flag", o_overflow, PROT);
        repeat (3) @(posedge i_clk);
        #1;
        chk("ovf_sticky", o_overflow, PROT);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
